nios_spi_slave: RTL and testbench

NIOS_SPI_SLAVE -- requirements
Module: nios_spi_slave

---
 rtl/nios_spi_pkg.sv | 24 ++
 rtl/nios_spi_sync.sv | 33 +++
 rtl/nios_spi_slave.sv | 190 +++++++++++++++++++
 tb/tb_nios_spi_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nios_spi_pkg.sv
// Shared definitions for the Nios-style SPI slave: register map, status/control
// bit positions and the frame state enumeration.
package nios_spi_pkg;

    localparam logic [2:0] ADDR_RX      = 3'd0;
    localparam logic [2:0] ADDR_TX      = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int unsigned BIT_E    = 9;
    localparam int unsigned BIT_RRDY = 8;
    localparam int unsigned BIT_TRDY = 7;
    localparam int unsigned BIT_TMT  = 6;
    localparam int unsigned BIT_TOE  = 5;
    localparam int unsigned BIT_ROE  = 4;
    localparam int unsigned BIT_TUR  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift
    } spi_state_e;

endpackage

// File: rtl/nios_spi_sync.sv
// Multi-flop synchronizer with rise/fall detection against a one-cycle delayed
// copy of the synchronized value. STAGES must be at least 2.
module nios_spi_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Resetting to 0 means an SS_n already low at reset release produces no
    // fall, so a frame in progress is ignored until the next fresh fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/nios_spi_slave.sv
// SPI mode-0 slave with a Nios-style CPU register interface (rx, tx, status,
// control) and a registered interrupt.
module nios_spi_slave
    import nios_spi_pkg::*;
#(
    parameter int unsigned DATABITS    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    localparam int unsigned CNT_W = $clog2(DATABITS + 1);

    logic w_sclk_q, w_sclk_rise, w_sclk_fall;
    logic w_ss_q, w_ss_rise, w_ss_fall;
    logic w_mosi_q, w_mosi_rise, w_mosi_fall;

    nios_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .i_d(SCLK),
        .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    nios_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .i_d(SS_n),
        .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );
    nios_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .i_d(MOSI),
        .o_q(w_mosi_q), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    logic w_unused;
    assign w_unused = w_sclk_q ^ w_mosi_rise ^ w_mosi_fall ^ (^data_from_cpu[15:10]);

    spi_state_e           r_state, w_state_next;
    logic [DATABITS-1:0]  r_shift, r_rx_holding, r_tx_holding;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_mosi_bit, r_tx_primed;
    logic                 r_rrdy, r_roe, r_toe, r_tur, r_irq;
    logic [6:0]           r_ien;
    logic [15:0]          r_data_to_cpu;
    logic                 r_rd_prev, r_wr_prev;
    logic                 w_load, w_shift_en, w_word_done, w_tmt;

    // Strobes fire only on the first cycle of a two-cycle access.
    logic w_rd_req, w_wr_req, w_rd_stb, w_wr_stb;
    assign w_rd_req = spi_select & ~read_n;
    assign w_wr_req = spi_select & ~write_n;
    assign w_rd_stb = w_rd_req & ~r_rd_prev;
    assign w_wr_stb = w_wr_req & ~r_wr_prev;

    logic w_tx_wr, w_stat_wr, w_ctrl_wr, w_rx_rd;
    assign w_tx_wr   = w_wr_stb & (mem_addr == ADDR_TX);
    assign w_stat_wr = w_wr_stb & (mem_addr == ADDR_STATUS);
    assign w_ctrl_wr = w_wr_stb & (mem_addr == ADDR_CONTROL);
    assign w_rx_rd   = w_rd_stb & (mem_addr == ADDR_RX);

    assign w_word_done = w_shift_en & w_sclk_fall & (r_bit_cnt == CNT_W'(DATABITS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_ss_rise) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (w_ss_fall) w_state_next = StLoad;
                StLoad:  w_state_next = StShift;
                StShift: if (w_word_done) w_state_next = StLoad;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        w_load     = (r_state == StLoad) & ~w_ss_rise;
        w_shift_en = (r_state == StShift) & ~w_ss_rise;
        w_tmt      = ~r_tx_primed & (r_state == StIdle);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_mosi_bit <= 1'b0;
        end else if (w_ss_rise) begin
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shift <= r_tx_primed ? r_tx_holding : '0;
        end else if (w_shift_en) begin
            if (w_sclk_rise) begin
                r_mosi_bit <= w_mosi_q;
                r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
            if (w_sclk_fall) begin
                r_shift <= {r_shift[DATABITS-2:0], r_mosi_bit};
                if (w_word_done) r_bit_cnt <= '0;
            end
        end
    end

    // Clears are applied first so that a same-cycle set event wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_holding <= '0;
            r_tx_holding <= '0;
            r_tx_primed  <= 1'b0;
            r_rrdy       <= 1'b0;
            r_roe        <= 1'b0;
            r_toe        <= 1'b0;
            r_tur        <= 1'b0;
            r_ien        <= '0;
        end else begin
            if (w_stat_wr) begin
                r_rrdy <= 1'b0;
                r_roe  <= 1'b0;
                r_toe  <= 1'b0;
                r_tur  <= 1'b0;
            end
            if (w_rx_rd) r_rrdy <= 1'b0;
            if (w_ctrl_wr) r_ien <= {data_from_cpu[9:7], 1'b0, data_from_cpu[5:3]};
            if (w_load && r_tx_primed) r_tx_primed <= 1'b0;
            if (w_load && !r_tx_primed) r_tur <= 1'b1;
            if (w_tx_wr) begin
                if (!r_tx_primed) begin
                    r_tx_holding <= data_from_cpu[DATABITS-1:0];
                    r_tx_primed  <= 1'b1;
                end else begin
                    r_toe <= 1'b1;
                end
            end
            if (w_word_done) begin
                r_rx_holding <= {r_shift[DATABITS-2:0], r_mosi_bit};
                r_rrdy       <= 1'b1;
                if (r_rrdy) r_roe <= 1'b1;
            end
        end
    end

    logic [15:0] w_status, w_control;
    assign w_status  = {6'b0, r_roe | r_toe | r_tur, r_rrdy, ~r_tx_primed, w_tmt,
                        r_toe, r_roe, r_tur, 3'b0};
    assign w_control = {6'b0, r_ien, 3'b0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_to_cpu <= '0;
            r_irq         <= 1'b0;
            r_rd_prev     <= 1'b0;
            r_wr_prev     <= 1'b0;
        end else begin
            r_rd_prev <= w_rd_req;
            r_wr_prev <= w_wr_req;
            r_irq     <= |(w_status[BIT_E:BIT_TUR] & r_ien);
            if (w_rd_stb) begin
                case (mem_addr)
                    ADDR_RX:      r_data_to_cpu <= 16'(r_rx_holding);
                    ADDR_TX:      r_data_to_cpu <= 16'(r_tx_holding);
                    ADDR_STATUS:  r_data_to_cpu <= w_status;
                    ADDR_CONTROL: r_data_to_cpu <= w_control;
                    default:      r_data_to_cpu <= '0;
                endcase
            end
        end
    end

    assign MISO          = ~w_ss_q & r_shift[DATABITS-1];
    assign data_to_cpu   = r_data_to_cpu;
    assign irq           = r_irq;
    assign dataavailable = r_rrdy;
    assign readyfordata  = ~r_tx_primed;

endmodule

// File: tb/tb_nios_spi_slave.sv
// Directed bench for nios_spi_slave: CPU register accesses and a mode-0 SPI
// master clocking at clk/8.
module tb_nios_spi_slave;

    logic        clk = 1'b0;
    logic        reset_n, SCLK, SS_n, MOSI, MISO;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        read_n, write_n, spi_select, irq, dataavailable, readyfordata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nios_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .mem_addr(mem_addr), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
        .read_n(read_n), .write_n(write_n), .spi_select(spi_select), .irq(irq),
        .dataavailable(dataavailable), .readyfordata(readyfordata)
    );

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [2:0] addr, input logic [15:0] data);
        spi_select = 1'b1; write_n = 1'b0; mem_addr = addr; data_from_cpu = data;
        wait_clks(2);
        spi_select = 1'b0; write_n = 1'b1;
        wait_clks(1);
    endtask

    task automatic cpu_read(input logic [2:0] addr, output logic [15:0] data);
        spi_select = 1'b1; read_n = 1'b0; mem_addr = addr;
        wait_clks(2);
        data = data_to_cpu;
        spi_select = 1'b0; read_n = 1'b1;
        wait_clks(1);
    endtask

    task automatic ss_set(input logic v);
        SS_n = v;
        wait_clks(8);
    endtask

    // Mode 0, MSB first: MISO sampled just before each rising SCLK edge.
    task automatic spi_bits(input logic [7:0] w, input int n, output logic [7:0] miso_w);
        miso_w = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = w[7-i];
            wait_clks(4);
            miso_w = {miso_w[6:0], MISO};
            SCLK = 1'b1;
            wait_clks(4);
            SCLK = 1'b0;
        end
        wait_clks(4);
        MOSI = 1'b0;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        n_tests++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", MISO); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_tests++; if (data_to_cpu !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", data_to_cpu); end
        n_tests++; if (dataavailable !== 1'b0) begin n_fail++; $display("FAIL reset_rrdy: got %b want 0", dataavailable); end
        n_tests++; if (readyfordata !== 1'b1) begin n_fail++; $display("FAIL reset_trdy: got %b want 1", readyfordata); end
        cpu_read(3'd2, d);
        n_tests++; if (d !== 16'h00C0) begin n_fail++; $display("FAIL reset_status: got %h want 00c0", d); end
        cpu_read(3'd3, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL reset_control: got %h want 0000", d); end
    endtask

    task automatic test_basic;
        logic [15:0] d;
        logic [7:0]  m;
        cpu_write(3'd1, 16'h00A5);
        n_tests++; if (readyfordata !== 1'b0) begin n_fail++; $display("FAIL basic_primed: got %b want 0", readyfordata); end
        ss_set(1'b0);
        spi_bits(8'h3C, 8, m);
        ss_set(1'b1);
        n_tests++; if (m !== 8'hA5) begin n_fail++; $display("FAIL basic_miso: got %h want a5", m); end
        n_tests++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL basic_miso_idle: got %b want 0", MISO); end
        n_tests++; if (dataavailable !== 1'b1) begin n_fail++; $display("FAIL basic_rrdy: got %b want 1", dataavailable); end
        n_tests++; if (readyfordata !== 1'b1) begin n_fail++; $display("FAIL basic_trdy: got %b want 1", readyfordata); end
        cpu_read(3'd2, d);
        n_tests++; if (d !== 16'h03C8) begin n_fail++; $display("FAIL basic_status: got %h want 03c8", d); end
        cpu_read(3'd0, d);
        n_tests++; if (d !== 16'h003C) begin n_fail++; $display("FAIL basic_rx: got %h want 003c", d); end
        n_tests++; if (dataavailable !== 1'b0) begin n_fail++; $display("FAIL basic_rrdy_clr: got %b want 0", dataavailable); end
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, d);
        n_tests++; if (d !== 16'h00C0) begin n_fail++; $display("FAIL basic_status_clr: got %h want 00c0", d); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        logic [7:0]  m1, m2;
        ss_set(1'b0);
        spi_bits(8'h11, 8, m1);
        spi_bits(8'h22, 8, m2);
        ss_set(1'b1);
        n_tests++; if ({m1, m2} !== 16'h0000) begin n_fail++; $display("FAIL b2b_miso: got %h want 0000", {m1, m2}); end
        cpu_read(3'd2, d);
        n_tests++; if (d !== 16'h03D8) begin n_fail++; $display("FAIL b2b_status: got %h want 03d8", d); end
        cpu_read(3'd0, d);
        n_tests++; if (d !== 16'h0022) begin n_fail++; $display("FAIL b2b_rx: got %h want 0022", d); end
        cpu_write(3'd2, 16'h0000);
    endtask

    task automatic test_underrun_irq;
        logic [15:0] d;
        logic [7:0]  m;
        cpu_write(3'd3, 16'h0008);
        cpu_read(3'd3, d);
        n_tests++; if (d !== 16'h0008) begin n_fail++; $display("FAIL tur_control: got %h want 0008", d); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL tur_irq_idle: got %b want 0", irq); end
        ss_set(1'b0);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL tur_irq_set: got %b want 1", irq); end
        spi_bits(8'h5A, 8, m);
        ss_set(1'b1);
        n_tests++; if (m !== 8'h00) begin n_fail++; $display("FAIL tur_miso: got %h want 00", m); end
        cpu_read(3'd0, d);
        n_tests++; if (d !== 16'h005A) begin n_fail++; $display("FAIL tur_rx: got %h want 005a", d); end
        cpu_write(3'd3, 16'h0000);
        cpu_write(3'd2, 16'h0000);
        wait_clks(2);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL tur_irq_clr: got %b want 0", irq); end
    endtask

    task automatic test_overrun_tx;
        logic [15:0] d;
        logic [7:0]  m;
        cpu_write(3'd1, 16'h0012);
        cpu_write(3'd1, 16'h0034);
        cpu_read(3'd2, d);
        n_tests++; if (d !== 16'h0220) begin n_fail++; $display("FAIL toe_status: got %h want 0220", d); end
        cpu_read(3'd1, d);
        n_tests++; if (d !== 16'h0012) begin n_fail++; $display("FAIL toe_kept: got %h want 0012", d); end
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, d);
        n_tests++; if (d !== 16'h0000) begin n_fail++; $display("FAIL toe_clr: got %h want 0000", d); end
        ss_set(1'b0);
        spi_bits(8'h00, 8, m);
        ss_set(1'b1);
        n_tests++; if (m !== 8'h12) begin n_fail++; $display("FAIL toe_drain_miso: got %h want 12", m); end
        cpu_write(3'd2, 16'h0000);
    endtask

    task automatic test_partial;
        logic [15:0] d;
        logic [7:0]  m;
        ss_set(1'b0);
        spi_bits(8'hF0, 4, m);
        ss_set(1'b1);
        n_tests++; if (dataavailable !== 1'b0) begin n_fail++; $display("FAIL part_rrdy: got %b want 0", dataavailable); end
        cpu_write(3'd1, 16'h00C3);
        ss_set(1'b0);
        spi_bits(8'h96, 8, m);
        ss_set(1'b1);
        n_tests++; if (m !== 8'hC3) begin n_fail++; $display("FAIL part_next_miso: got %h want c3", m); end
        cpu_read(3'd0, d);
        n_tests++; if (d !== 16'h0096) begin n_fail++; $display("FAIL part_next_rx: got %h want 0096", d); end
        cpu_write(3'd2, 16'h0000);
    endtask

    task automatic test_reset_midframe;
        logic [15:0] d;
        logic [7:0]  m;
        cpu_write(3'd3, 16'h0200);
        cpu_write(3'd1, 16'h0077);
        ss_set(1'b0);
        spi_bits(8'hA0, 3, m);
        cpu_read(3'd3, d);
        reset_n = 1'b0;
        wait_clks(2);
        n_tests++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL rst_mid_miso: got %b want 0", MISO); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq: got %b want 0", irq); end
        n_tests++; if (data_to_cpu !== 16'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0000", data_to_cpu); end
        n_tests++; if (readyfordata !== 1'b1) begin n_fail++; $display("FAIL rst_mid_trdy: got %b want 1", readyfordata); end
        n_tests++; if (dataavailable !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rrdy: got %b want 0", dataavailable); end
        reset_n = 1'b1;
        wait_clks(2);
        spi_bits(8'hFF, 5, m);
        n_tests++; if (m !== 8'h00) begin n_fail++; $display("FAIL rst_mid_tail_miso: got %h want 00", m); end
        ss_set(1'b1);
        n_tests++; if (dataavailable !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tail_rrdy: got %b want 0", dataavailable); end
        cpu_write(3'd1, 16'h00E1);
        ss_set(1'b0);
        spi_bits(8'h4B, 8, m);
        ss_set(1'b1);
        n_tests++; if (m !== 8'hE1) begin n_fail++; $display("FAIL rst_next_miso: got %h want e1", m); end
        cpu_read(3'd0, d);
        n_tests++; if (d !== 16'h004B) begin n_fail++; $display("FAIL rst_next_rx: got %h want 004b", d); end
    endtask

    initial begin
        reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        mem_addr = 3'd0; data_from_cpu = 16'h0;
        read_n = 1'b1; write_n = 1'b1; spi_select = 1'b0;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(3);
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun_irq();
        test_overrun_tx();
        test_partial();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
